// File: rtl/fifo_deq_serializer.sv
// Drains a first/deq style FIFO head and emits each wide word as a sequence of
// narrower beats (LSB first) on an enq-style ENA/RDY downstream interface.
module fifo_deq_serializer #(
   parameter int width      = 32,
   parameter int beat_width = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [width-1:0]      in_first,
   input  logic                  in_first_rdy,
   output logic                  in_deq_ena,
   input  logic                  in_deq_rdy,
   output logic                  out_enq_ena,
   output logic [beat_width-1:0] out_enq_v,
   output logic                  out_enq_last,
   input  logic                  out_enq_rdy,
   output logic                  busy
);

   localparam int ratio = width / beat_width;
   localparam int cw    = (ratio > 1) ? $clog2(ratio) : 1;
   localparam logic [cw-1:0] last_cnt = cw'(ratio - 1);

   logic [width-1:0] shreg;
   logic [cw-1:0]    cnt;
   logic             valid;
   logic             last_fire;

   assign out_enq_v    = shreg[beat_width-1:0];
   assign out_enq_last = (cnt == last_cnt);
   assign busy         = valid;
   assign out_enq_ena  = valid && out_enq_rdy;
   assign last_fire    = out_enq_ena && out_enq_last;
   // A new word may be popped on the same edge the previous word's last beat leaves.
   assign in_deq_ena   = in_first_rdy && in_deq_rdy && (!valid || last_fire);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shreg <= '0;
         cnt   <= '0;
         valid <= 1'b0;
      end else if (in_deq_ena) begin
         shreg <= in_first;
         cnt   <= '0;
         valid <= 1'b1;
      end else if (out_enq_ena) begin
         if (!out_enq_last) begin
            shreg <= shreg >> beat_width;
            cnt   <= cnt + cw'(1);
         end else begin
            valid <= 1'b0;
            cnt   <= '0;
         end
      end
   end

endmodule

// File: tb/tb_fifo_deq_serializer.sv
// Bench for fifo_deq_serializer: a 32->8 instance and an 8->8 instance, each
// with a scoreboard of expected beats fed from the words it pops.
module tb_fifo_deq_serializer;

   logic        clk;
   logic        rst_n;
   logic [31:0] in_first;
   logic        in_first_rdy;
   logic        in_deq_ena;
   logic        in_deq_rdy;
   logic        out_enq_ena;
   logic [7:0]  out_enq_v;
   logic        out_enq_last;
   logic        out_enq_rdy;
   logic        busy;

   logic [7:0]  b_first;
   logic        b_first_rdy;
   logic        b_deq_ena;
   logic        b_deq_rdy;
   logic        b_enq_ena;
   logic [7:0]  b_enq_v;
   logic        b_enq_last;
   logic        b_enq_rdy;
   logic        b_busy;

   int errors = 0;
   int checks = 0;
   logic [8:0] sb_a[$];
   logic [8:0] sb_b[$];

   fifo_deq_serializer #(.width(32), .beat_width(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_first(in_first), .in_first_rdy(in_first_rdy), .in_deq_ena(in_deq_ena),
      .in_deq_rdy(in_deq_rdy), .out_enq_ena(out_enq_ena), .out_enq_v(out_enq_v),
      .out_enq_last(out_enq_last), .out_enq_rdy(out_enq_rdy), .busy(busy)
   );

   fifo_deq_serializer #(.width(8), .beat_width(8)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .in_first(b_first), .in_first_rdy(b_first_rdy), .in_deq_ena(b_deq_ena),
      .in_deq_rdy(b_deq_rdy), .out_enq_ena(b_enq_ena), .out_enq_v(b_enq_v),
      .out_enq_last(b_enq_last), .out_enq_rdy(b_enq_rdy), .busy(b_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboards: pops push the bench's own driven word, fired beats are popped and compared.
   always @(negedge clk) begin
      logic [8:0] exp;
      if (rst_n === 1'b1) begin
         if (out_enq_ena) begin
            checks++;
            if (sb_a.size() == 0) begin
               errors++;
               $display("FAIL sb_a_underflow: got beat %h, expected none", out_enq_v);
            end else begin
               exp = sb_a.pop_front();
               if ({out_enq_last, out_enq_v} !== exp) begin
                  errors++;
                  $display("FAIL sb_a_beat: got last=%b v=%h, expected last=%b v=%h",
                           out_enq_last, out_enq_v, exp[8], exp[7:0]);
               end
            end
         end
         if (in_deq_ena)
            for (int k = 0; k < 4; k++) sb_a.push_back({(k == 3), in_first[k*8 +: 8]});
         if (b_enq_ena) begin
            checks++;
            if (sb_b.size() == 0) begin
               errors++;
               $display("FAIL sb_b_underflow: got beat %h, expected none", b_enq_v);
            end else begin
               exp = sb_b.pop_front();
               if ({b_enq_last, b_enq_v} !== exp) begin
                  errors++;
                  $display("FAIL sb_b_beat: got last=%b v=%h, expected last=%b v=%h",
                           b_enq_last, b_enq_v, exp[8], exp[7:0]);
               end
            end
         end
         if (b_deq_ena) sb_b.push_back({1'b1, b_first});
      end
   end

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++;
      if ({out_enq_ena, in_deq_ena, busy, out_enq_last, out_enq_v} !== 12'h0) begin
         errors++;
         $display("FAIL reset_state: got ena=%b deq=%b busy=%b last=%b v=%h, expected all 0",
                  out_enq_ena, in_deq_ena, busy, out_enq_last, out_enq_v);
      end
      checks++;
      if ({b_enq_ena, b_busy} !== 2'b00) begin
         errors++;
         $display("FAIL reset_state_b: got ena=%b busy=%b, expected 0 0", b_enq_ena, b_busy);
      end
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
   endtask

   task automatic test_single();
      logic [31:0] w;
      w = 32'hDDCCBBAA;
      in_first = w; in_first_rdy = 1'b1; in_deq_rdy = 1'b1; out_enq_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (in_deq_ena !== 1'b1) begin
         errors++;
         $display("FAIL single_deq: got %b, expected 1", in_deq_ena);
      end
      next_cycle();
      in_first_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({out_enq_ena, out_enq_last, out_enq_v, in_deq_ena} !==
             {1'b1, (i == 3), w[i*8 +: 8], 1'b0}) begin
            errors++;
            $display("FAIL single_beat%0d: got ena=%b last=%b v=%h deq=%b, expected 1 %b %h 0",
                     i, out_enq_ena, out_enq_last, out_enq_v, in_deq_ena, (i == 3), w[i*8 +: 8]);
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if ({busy, out_enq_ena} !== 2'b00) begin
         errors++;
         $display("FAIL single_idle: got busy=%b ena=%b, expected 0 0", busy, out_enq_ena);
      end
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [63:0] pair;
      pair = 64'h08070605_04030201;
      in_first = pair[31:0]; in_first_rdy = 1'b1; in_deq_rdy = 1'b1; out_enq_rdy = 1'b1;
      next_cycle();
      for (int i = 0; i < 8; i++) begin
         if (i == 0) in_first = pair[63:32];
         if (i == 4) in_first_rdy = 1'b0;
         @(negedge clk);
         checks++;
         if ({out_enq_ena, out_enq_v, in_deq_ena} !== {1'b1, pair[i*8 +: 8], (i == 3)}) begin
            errors++;
            $display("FAIL b2b_beat%0d: got ena=%b v=%h deq=%b, expected 1 %h %b",
                     i, out_enq_ena, out_enq_v, in_deq_ena, pair[i*8 +: 8], (i == 3));
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL b2b_idle: got busy=%b, expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_backpressure();
      logic [6:0]  pat;
      logic [31:0] w;
      int idx;
      pat = 7'b1011001;
      w = 32'h44332211;
      idx = 0;
      in_first = w; in_first_rdy = 1'b1; in_deq_rdy = 1'b1; out_enq_rdy = 1'b0;
      next_cycle();
      in_first = 32'h88776655;
      for (int i = 0; i < 7; i++) begin
         out_enq_rdy = pat[i];
         @(negedge clk);
         checks++;
         if ({out_enq_ena, out_enq_v, in_deq_ena} !==
             {pat[i], w[idx*8 +: 8], (pat[i] && idx == 3)}) begin
            errors++;
            $display("FAIL bp_cycle%0d: got ena=%b v=%h deq=%b, expected %b %h %b",
                     i, out_enq_ena, out_enq_v, in_deq_ena, pat[i], w[idx*8 +: 8],
                     (pat[i] && idx == 3));
         end
         if (pat[i]) idx++;
         next_cycle();
      end
      in_first_rdy = 1'b0; out_enq_rdy = 1'b1;
      repeat (5) next_cycle();
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("FAIL bp_drain: got busy=%b, expected 0", busy);
      end
      next_cycle();
   endtask

   task automatic test_deq_stall();
      in_first = 32'hCAFEF00D; in_first_rdy = 1'b1; in_deq_rdy = 1'b0; out_enq_rdy = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({in_deq_ena, busy} !== 2'b00) begin
            errors++;
            $display("FAIL stall_cycle%0d: got deq=%b busy=%b, expected 0 0", i, in_deq_ena, busy);
         end
         next_cycle();
      end
      in_deq_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if (in_deq_ena !== 1'b1) begin
         errors++;
         $display("FAIL stall_release: got deq=%b, expected 1", in_deq_ena);
      end
      next_cycle();
      in_first_rdy = 1'b0;
      @(negedge clk);
      checks++;
      if ({out_enq_ena, out_enq_v, in_deq_ena} !== {1'b1, 8'h0D, 1'b0}) begin
         errors++;
         $display("FAIL stall_first_beat: got ena=%b v=%h deq=%b, expected 1 0d 0",
                  out_enq_ena, out_enq_v, in_deq_ena);
      end
      repeat (5) next_cycle();
   endtask

   task automatic test_async_reset();
      logic [31:0] w;
      in_first = 32'hDDCCBBAA; in_first_rdy = 1'b1; in_deq_rdy = 1'b1; out_enq_rdy = 1'b1;
      next_cycle();
      in_first_rdy = 1'b0;
      next_cycle();
      next_cycle();
      checks++;
      if ({busy, out_enq_v} !== {1'b1, 8'hCC}) begin
         errors++;
         $display("FAIL arst_pre: got busy=%b v=%h, expected 1 cc", busy, out_enq_v);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({out_enq_ena, busy, out_enq_v} !== 10'h0) begin
         errors++;
         $display("FAIL arst_immediate: got ena=%b busy=%b v=%h, expected 0 0 00",
                  out_enq_ena, busy, out_enq_v);
      end
      sb_a.delete();
      sb_b.delete();
      next_cycle();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({out_enq_ena, busy} !== 2'b00) begin
            errors++;
            $display("FAIL arst_quiet%0d: got ena=%b busy=%b, expected 0 0", i, out_enq_ena, busy);
         end
         next_cycle();
      end
      w = 32'h11223344;
      in_first = w; in_first_rdy = 1'b1;
      next_cycle();
      in_first_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++;
         if ({out_enq_ena, out_enq_last, out_enq_v} !== {1'b1, (i == 3), w[i*8 +: 8]}) begin
            errors++;
            $display("FAIL arst_new_beat%0d: got ena=%b last=%b v=%h, expected 1 %b %h",
                     i, out_enq_ena, out_enq_last, out_enq_v, (i == 3), w[i*8 +: 8]);
         end
         next_cycle();
      end
   endtask

   task automatic test_ratio_one();
      logic [23:0] words;
      words = 24'hFFA55A;
      b_first = words[7:0]; b_first_rdy = 1'b1; b_deq_rdy = 1'b1; b_enq_rdy = 1'b1;
      @(negedge clk);
      checks++;
      if ({b_deq_ena, b_enq_ena} !== 2'b10) begin
         errors++;
         $display("FAIL r1_load: got deq=%b ena=%b, expected 1 0", b_deq_ena, b_enq_ena);
      end
      next_cycle();
      for (int i = 0; i < 3; i++) begin
         if (i < 2) b_first = words[(i+1)*8 +: 8];
         else b_first_rdy = 1'b0;
         @(negedge clk);
         checks++;
         if ({b_enq_ena, b_enq_last, b_enq_v, b_deq_ena} !== {1'b1, 1'b1, words[i*8 +: 8], (i < 2)}) begin
            errors++;
            $display("FAIL r1_beat%0d: got ena=%b last=%b v=%h deq=%b, expected 1 1 %h %b",
                     i, b_enq_ena, b_enq_last, b_enq_v, b_deq_ena, words[i*8 +: 8], (i < 2));
         end
         next_cycle();
      end
      @(negedge clk);
      checks++;
      if (b_busy !== 1'b0) begin
         errors++;
         $display("FAIL r1_idle: got busy=%b, expected 0", b_busy);
      end
      next_cycle();
   endtask

   initial begin
      rst_n = 1'b1;
      in_first = '0; in_first_rdy = 1'b0; in_deq_rdy = 1'b0; out_enq_rdy = 1'b1;
      b_first = '0; b_first_rdy = 1'b0; b_deq_rdy = 1'b0; b_enq_rdy = 1'b1;
      #1 rst_n = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_deq_stall();
      test_async_reset();
      test_ratio_one();
      repeat (2) next_cycle();
      checks++;
      if (sb_a.size() != 0 || sb_b.size() != 0) begin
         errors++;
         $display("FAIL sb_leftover: got %0d/%0d pending beats, expected 0/0", sb_a.size(), sb_b.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fifo_deq_serializer.md
Name: fifo_deq_serializer

Overview:
- Reader-side companion to the single-entry FIFO. It drains the FIFO's first/deq interface and serializes each width-bit word into width/beatWidth narrower beats.
- Beats are pushed into a downstream enq-style interface using ENA/RDY method handshakes.
- Used wherever a wide FIFO output feeds a narrow datapath, such as byte streams or narrow buses.

Parameters:
- width, 32, upstream word width in bits.
- beatWidth, 8, downstream beat width in bits. width must be an integer multiple of beatWidth.
- Derived: ratio = width/beatWidth (must be >= 1). Counter width cw = max(1, clog2(ratio)).

Ports:
- CLK  input  1  clock, rising edge.
- nRST  input  1  reset, asynchronous, active-low.
- in$first  input  width  upstream head-of-FIFO data.
- in$first__RDY  input  1  upstream head is valid.
- in$deq__ENA  output  1  pop upstream head this cycle.
- in$deq__RDY  input  1  upstream can accept deq.
- out$enq__ENA  output  1  push beat downstream this cycle.
- out$enq$v  output  beatWidth  beat data.
- out$enq$last  output  1  current beat is the final beat of its word.
- out$enq__RDY  input  1  downstream can accept a beat.
- busy  output  1  a word is held (valid flag).

Behaviour:
- Reset and state:
  - Asynchronous reset: nRST low clears shreg (width), cnt (cw), and valid immediately, without waiting for CLK.
  - Reset values: in$deq__ENA=0, out$enq__ENA=0, out$enq$v=0, out$enq$last=0 (when ratio>1), busy=0.
- Combinational outputs:
  - out$enq$v = shreg[beatWidth-1:0]. Beats go out LSB first.
  - out$enq$last = (cnt == ratio-1).
  - busy = valid.
  - out$enq__ENA = valid && out$enq__RDY. ENA is never asserted without RDY.
  - lastFire = out$enq__ENA && out$enq$last.
  - in$deq__ENA = in$first__RDY && in$deq__RDY && (!valid || lastFire).
- Load, on the clock edge when in$deq__ENA is high:
  - shreg <= in$first, cnt <= 0, valid <= 1.
  - This takes priority over the shift or clear below.
- Beat fire without load, when out$enq__ENA is high:
  - If not the last beat: shreg <= shreg >> beatWidth, cnt <= cnt+1.
  - If the last beat: valid <= 0, cnt <= 0, shreg holds.
- Latency and throughput:
  - A word popped at edge N presents its first beat in cycle N+1.
  - A back-to-back word is loaded on the same edge as the previous word's last beat, so there is no bubble.
  - Sustained throughput is one beat per cycle, i.e. ratio cycles per word.
- Backpressure:
  - With out$enq__RDY low, shreg, cnt, and valid hold.
  - No deq is issued while valid and not on the last beat.
- Upstream empty (in$first__RDY=0) on the last beat: valid clears and busy drops the next cycle.
- in$deq__RDY low while in$first__RDY is high: no pop. The block waits; in$first is never sampled without deq.
- ratio==1:
  - out$enq$last is constantly 1.
  - The block acts as a 1-deep pipeline register with full-rate pass-through.
- Reset mid-word: the partial word is discarded, and no further beats of it are emitted after reset is released.
- No data loss or duplication: each popped word yields exactly ratio beats, in order.

Test Plan:
- Reset, then upstream offers 0xDDCCBBAA with downstream RDY=1 → one deq pulse. Beats 0xAA, 0xBB, 0xCC, 0xDD appear on consecutive cycles; last=1 only on 0xDD; busy drops the cycle after.
- Two words 0x04030201 and 0x08070605 held ready → deq of the second coincides with beat 0x04. Beats 01..08 are emitted over 8 consecutive cycles with no bubble.
- Downstream RDY pattern 1,0,0,1,1,0,1 on word 0x44332211 → ENA asserts only when RDY=1. Beats 11,22,33,44 keep their order; no deq occurs before 0x44 fires.
- in$first__RDY=1 with in$deq__RDY=0 for 3 cycles, then 1 → in$deq__ENA stays 0 for 3 cycles, then pulses once; first beat follows one cycle later.
- Assert nRST low asynchronously mid-cycle after beat 0xBB → ENA and busy fall immediately without a clock edge. After release with upstream empty, no beats are emitted; a new word 0x11223344 then yields 44,33,22,11.
- width=8, beatWidth=8: stream 0x5A, 0xA5, 0xFF → one beat per cycle after a 1-cycle latency, last=1 on every beat.
